// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the iterative restoring divider:
//   DEF_DW / DEF_VW : default dividend/quotient and divisor/remainder widths
//   CNT_W           : step counter width for the default dividend width
//   state_t         : controller states IDLE -> RUN -> DONE -> IDLE
// -----------------------------------------------------------------------------
package div_pkg;

  localparam int DEF_DW = 16;
  localparam int DEF_VW = 8;
  localparam int CNT_W  = $clog2(DEF_DW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step.
//   rem_i  [VW-1:0] : partial remainder entering the step
//   msb_i           : next dividend bit shifted into the trial value
//   div_i  [VW-1:0] : divisor
//   rem_o  [VW-1:0] : partial remainder leaving the step
//   qbit_o          : quotient bit produced by this step
// The trial value T = {rem, msb} is VW+1 bits wide. Only its low VW bits are
// carried forward, because the next step rebuilds T from rem[VW-1:0] alone.
// -----------------------------------------------------------------------------
module div_step
  #(parameter int VW = 8)
  (
    input  logic [VW-1:0] rem_i,
    input  logic          msb_i,
    input  logic [VW-1:0] div_i,
    output logic [VW-1:0] rem_o,
    output logic          qbit_o
  );

  logic [VW:0] trial_s;
  logic        ge_s;

  // Build the trial value; subtract the divisor when it fits, else restore.
  always_comb begin
    trial_s = {rem_i, msb_i};
    ge_s    = (trial_s >= {1'b0, div_i});
    if (ge_s) begin
      rem_o  = VW'(trial_s - {1'b0, div_i});
      qbit_o = 1'b1;
    end else begin
      rem_o  = trial_s[VW-1:0];
      qbit_o = 1'b0;
    end
  end

endmodule

// File: rtl/div_restoring_u16x8.sv
// -----------------------------------------------------------------------------
// div_restoring_u16x8
// Iterative unsigned restoring divider, one quotient bit per clock.
//   clk   : rising-edge clock
//   clrn  : asynchronous active-low reset
//   start : request, accepted on a rising edge while busy=0
//   a     : dividend (DW bits), captured with start
//   b     : divisor  (VW bits), captured with start
//   busy  : division in progress
//   ready : one-cycle pulse, q/r/dz valid from this cycle on
//   q     : quotient  (DW bits, held until the next completion)
//   r     : remainder (VW bits, held until the next completion)
//   dz    : divide-by-zero flag
// Build option DIV_ZERO_DETECT_EN: when defined, b==0 is caught at accept and
// the result is produced one clock later with dz=1. When undefined, b==0
// simply runs the normal DW steps (which yield q=all ones, r=a[VW-1:0]) and dz
// stays 0.
// -----------------------------------------------------------------------------
module div_restoring_u16x8
  import div_pkg::*;
  #(
    parameter int DW = DEF_DW,
    parameter int VW = DEF_VW
  )
  (
    input  logic          clk,
    input  logic          clrn,
    input  logic          start,
    input  logic [DW-1:0] a,
    input  logic [VW-1:0] b,
    output logic          busy,
    output logic          ready,
    output logic [DW-1:0] q,
    output logic [VW-1:0] r,
    output logic          dz
  );

  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] LAST_CNT = CW'(DW - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [VW-1:0] rem_q,   rem_d;   // partial remainder, always < divisor when b != 0
  logic [DW-1:0] dvd_q,   dvd_d;   // dividend shifts out of the top, quotient in at the bottom
  logic [VW-1:0] dvs_q,   dvs_d;
  logic          busy_q,  busy_d;
  logic          ready_q, ready_d;
  logic [DW-1:0] quo_q,   quo_d;
  logic [VW-1:0] rmd_q,   rmd_d;
  logic          dz_q,    dz_d;
`ifdef DIV_ZERO_DETECT_EN
  logic          zpend_q, zpend_d; // current operation has a zero divisor
`endif

  logic [VW-1:0] step_rem_s;
  logic          step_qbit_s;

  div_step #(.VW(VW)) u_step (
    .rem_i  (rem_q),
    .msb_i  (dvd_q[DW-1]),
    .div_i  (dvs_q),
    .rem_o  (step_rem_s),
    .qbit_o (step_qbit_s)
  );

  // Controller next-state, datapath updates and result capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    busy_d  = busy_q;
    ready_d = 1'b0;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dz_d    = dz_q;
`ifdef DIV_ZERO_DETECT_EN
    zpend_d = zpend_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Accept: results are deliberately left untouched until completion.
          state_d = RUN;
          cnt_d   = {CW{1'b0}};
          rem_d   = {VW{1'b0}};
          dvd_d   = a;
          dvs_d   = b;
          busy_d  = 1'b1;
`ifdef DIV_ZERO_DETECT_EN
          zpend_d = (b == {VW{1'b0}});
`endif
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      RUN: begin
`ifdef DIV_ZERO_DETECT_EN
        if (zpend_q) begin
          // Short-cut: the untouched dividend still sits in dvd_q.
          state_d = DONE;
          busy_d  = 1'b0;
          ready_d = 1'b1;
          quo_d   = {DW{1'b1}};
          rmd_d   = dvd_q[VW-1:0];
          dz_d    = 1'b1;
          zpend_d = 1'b0;
        end else begin
`endif
          rem_d = step_rem_s;
          dvd_d = {dvd_q[DW-2:0], step_qbit_s};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_CNT) begin
            state_d = DONE;
            busy_d  = 1'b0;
            ready_d = 1'b1;
            quo_d   = {dvd_q[DW-2:0], step_qbit_s};
            rmd_d   = step_rem_s;
            dz_d    = 1'b0;
          end else begin
            state_d = RUN;
          end
`ifdef DIV_ZERO_DETECT_EN
        end
`endif
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
      cnt_q   <= {CW{1'b0}};
      rem_q   <= {VW{1'b0}};
      dvd_q   <= {DW{1'b0}};
      dvs_q   <= {VW{1'b0}};
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      quo_q   <= {DW{1'b0}};
      rmd_q   <= {VW{1'b0}};
      dz_q    <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
      zpend_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dz_q    <= dz_d;
`ifdef DIV_ZERO_DETECT_EN
      zpend_q <= zpend_d;
`endif
    end
  end

  assign busy  = busy_q;
  assign ready = ready_q;
  assign q     = quo_q;
  assign r     = rmd_q;
  assign dz    = dz_q;

endmodule

// File: tb/tb_div_restoring_u16x8.sv
// -----------------------------------------------------------------------------
// tb_div_restoring_u16x8
// Scoreboard bench: expected quotient/remainder/flag/latency are computed from
// the operands when a request is issued and compared when ready pulses.
// -----------------------------------------------------------------------------
module tb_div_restoring_u16x8;

`ifdef DIV_ZERO_DETECT_EN
  localparam logic ZDZ  = 1'b1;
  localparam int   ZLAT = 1;
`else
  localparam logic ZDZ  = 1'b0;
  localparam int   ZLAT = 16;
`endif

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = 16'd0;
  logic [7:0]  b = 8'd0;
  logic        busy, ready, dz;
  logic [15:0] q;
  logic [7:0]  r;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cyc = 0;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
    int          lat;
  } exp_t;
  exp_t sb[$];

  div_restoring_u16x8 dut (
    .clk   (clk),
    .clrn  (clrn),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .ready (ready),
    .q     (q),
    .r     (r),
    .dz    (dz)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Issue one request; optionally record its expected result.
  task automatic start_op(input logic [15:0] av, input logic [7:0] bv, input bit push);
    exp_t e;
    logic [15:0] rem16;
    if (push) begin
      if (bv == 8'd0) begin
        e.q   = 16'hFFFF;
        e.r   = av[7:0];
        e.dz  = ZDZ;
        e.lat = ZLAT;
      end else begin
        e.q   = av / {8'd0, bv};
        rem16 = av % {8'd0, bv};
        e.r   = rem16[7:0];
        e.dz  = 1'b0;
        e.lat = 16;
      end
      sb.push_back(e);
    end
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    acc_cyc = cyc;
  endtask

  // Wait (bounded) for ready and compare against the oldest expectation.
  task automatic wait_done(input string name);
    int   bad;
    exp_t e;
    bad = 0;
    while (ready !== 1'b1 && (cyc - acc_cyc) < 40) begin
      if (busy !== 1'b1) bad++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_timeout ready=%b after %0d cycles", name, ready, cyc - acc_cyc);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s_unexpected ready=%b with empty scoreboard", name, ready);
      return;
    end
    e = sb.pop_front();
    checks++;
    if ((cyc - acc_cyc) !== e.lat) begin
      failures++;
      $display("FAIL %s_latency got=%0d exp=%0d", name, cyc - acc_cyc, e.lat);
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL %s_busy_run got=%0d low cycles exp=0", name, bad);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_busy_done got=%b exp=0", name, busy);
    end
    checks++;
    if (q !== e.q) begin
      failures++;
      $display("FAIL %s_q got=%0d exp=%0d", name, q, e.q);
    end
    checks++;
    if (r !== e.r) begin
      failures++;
      $display("FAIL %s_r got=%0d exp=%0d", name, r, e.r);
    end
    checks++;
    if (dz !== e.dz) begin
      failures++;
      $display("FAIL %s_dz got=%b exp=%b", name, dz, e.dz);
    end
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++;
    if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ready); end
    checks++;
    if (q !== 16'd0) begin failures++; $display("FAIL reset_q got=%0d exp=0", q); end
    checks++;
    if (r !== 8'd0) begin failures++; $display("FAIL reset_r got=%0d exp=0", r); end
    checks++;
    if (dz !== 1'b0) begin failures++; $display("FAIL reset_dz got=%b exp=0", dz); end
    clrn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    start_op(16'd1000, 8'd7, 1'b1);
    wait_done("basic");
    @(posedge clk);
    #1;
    checks++;
    if (ready !== 1'b0) begin failures++; $display("FAIL basic_ready_pulse got=%b exp=0", ready); end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (q !== 16'd142 || r !== 8'd6) begin
      failures++;
      $display("FAIL basic_hold got=%0d/%0d exp=142/6", q, r);
    end
  endtask

  task automatic test_back_to_back();
    start_op(16'd65535, 8'd255, 1'b1);
    wait_done("b2b_first");
    start_op(16'd5, 8'd9, 1'b1);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept_busy got=%b exp=1", busy); end
    checks++;
    if (q !== 16'd257 || r !== 8'd0) begin
      failures++;
      $display("FAIL b2b_result_kept got=%0d/%0d exp=257/0", q, r);
    end
    wait_done("b2b_second");
    @(posedge clk);
    #1;
  endtask

  task automatic test_div_zero();
    start_op(16'h1234, 8'd0, 1'b1);
    wait_done("div_zero");
    @(posedge clk);
    #1;
  endtask

  task automatic test_ignore_start();
    start_op(16'd100, 8'd3, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    a = 16'd9;
    b = 8'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 16'd0;
    b = 8'd0;
    wait_done("ignore_start");
    @(posedge clk);
    #1;
  endtask

  task automatic test_abort();
    int seen;
    seen = 0;
    start_op(16'd1000, 8'd7, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    clrn = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++;
    if (q !== 16'd0 || r !== 8'd0 || dz !== 1'b0) begin
      failures++;
      $display("FAIL abort_outputs got=%0d/%0d/%b exp=0/0/0", q, r, dz);
    end
    repeat (2) begin
      @(posedge clk);
      #1;
      if (ready === 1'b1) seen++;
    end
    clrn = 1'b1;
    repeat (18) begin
      @(posedge clk);
      #1;
      if (ready === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL abort_no_ready got=%0d pulses exp=0", seen); end
    start_op(16'd200, 8'd10, 1'b1);
    wait_done("after_abort");
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [15:0] av;
    logic [7:0]  bv;
    for (int i = 0; i < 1500; i++) begin
      if (i % 4 == 0) av = 16'($urandom_range(0, 300));
      else av = 16'($urandom);
      bv = 8'($urandom_range(1, 255));
      start_op(av, bv, 1'b1);
      wait_done("random");
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_ignore_start();
    test_abort();
    test_random();
    checks++;
    if (sb.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d pending exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
